// File: rtl/sram_arbiter_if.sv
// Requester A/B and SRAM-controller bus seen by sram_arbiter.
interface sram_arbiter_if;
    logic        i_a_req;
    logic        i_a_wren;
    logic [31:0] i_a_addr;
    logic [31:0] i_a_wdata;
    logic [3:0]  i_a_bmask;
    logic        o_a_ack;
    logic [31:0] o_a_rdata;

    logic        i_b_req;
    logic        i_b_wren;
    logic [31:0] i_b_addr;
    logic [31:0] i_b_wdata;
    logic [3:0]  i_b_bmask;
    logic        o_b_ack;
    logic [31:0] o_b_rdata;

    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [3:0]  o_mem_bmask;
    logic        o_mem_wren;
    logic        o_mem_rden;
    logic [31:0] i_mem_rdata;
    logic        i_mem_ack;

    // Arbiter side
    modport slave (
        input  i_a_req, i_a_wren, i_a_addr, i_a_wdata, i_a_bmask,
        output o_a_ack, o_a_rdata,
        input  i_b_req, i_b_wren, i_b_addr, i_b_wdata, i_b_bmask,
        output o_b_ack, o_b_rdata,
        output o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren, o_mem_rden,
        input  i_mem_rdata, i_mem_ack
    );

    // Requester / SRAM-controller side
    modport master (
        output i_a_req, i_a_wren, i_a_addr, i_a_wdata, i_a_bmask,
        input  o_a_ack, o_a_rdata,
        output i_b_req, i_b_wren, i_b_addr, i_b_wdata, i_b_bmask,
        input  o_b_ack, o_b_rdata,
        input  o_mem_addr, o_mem_wdata, o_mem_bmask, o_mem_wren, o_mem_rden,
        output i_mem_rdata, i_mem_ack
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin arbiter between two requesters sharing one SRAM controller,
// with address-range filtering, ack timeout and sticky error flags.
module sram_arbiter #(
    parameter logic [31:0] SRAM_MIN    = 32'h2000,
    parameter logic [31:0] SRAM_MAX    = 32'h3FFF,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_err_clr,
    output logic [1:0]    o_err,
    output logic          o_busy,
    sram_arbiter_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_RESP} state_t;

    state_t           r_state;
    state_t           w_next;

    logic             r_last_b;
    logic             r_win_b;
    logic             r_cmd_wren;
    logic [31:0]      r_cmd_addr;
    logic [31:0]      r_cmd_wdata;
    logic [3:0]       r_cmd_bmask;
    logic [CNT_W-1:0] r_cnt;
    logic             r_hold;
    logic             r_mem_wren;
    logic             r_mem_rden;
    logic             r_a_ack;
    logic             r_b_ack;
    logic [31:0]      r_a_rdata;
    logic [31:0]      r_b_rdata;
    logic             r_busy;
    logic [1:0]       r_err;

    logic             w_any_req;
    logic             w_sel_b;
    logic             w_sel_wren;
    logic [31:0]      w_sel_addr;
    logic [31:0]      w_sel_wdata;
    logic [3:0]       w_sel_bmask;
    logic             w_in_range;
    logic             w_latch;
    logic             w_set_oor;
    logic             w_set_tmo;
    logic             w_fire;
    logic             w_cnt_inc;
    logic [31:0]      w_resp_data;
    logic             w_en_wren;
    logic             w_en;

    // Winner select: lone requester wins, a tie goes to the port not served last
    assign w_any_req   = bus.i_a_req | bus.i_b_req;
    assign w_sel_b     = bus.i_b_req & (~bus.i_a_req | ~r_last_b);
    assign w_sel_wren  = w_sel_b ? bus.i_b_wren  : bus.i_a_wren;
    assign w_sel_addr  = w_sel_b ? bus.i_b_addr  : bus.i_a_addr;
    assign w_sel_wdata = w_sel_b ? bus.i_b_wdata : bus.i_a_wdata;
    assign w_sel_bmask = w_sel_b ? bus.i_b_bmask : bus.i_a_bmask;
    assign w_in_range  = (w_sel_addr >= SRAM_MIN) && (w_sel_addr <= SRAM_MAX);

    // State register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next state and per-cycle control; out-of-range requests spend one extra
    // RESP cycle (r_hold) so their ack lands two cycles after the request
    always_comb begin
        w_next      = r_state;
        w_latch     = 1'b0;
        w_set_oor   = 1'b0;
        w_set_tmo   = 1'b0;
        w_fire      = 1'b0;
        w_cnt_inc   = 1'b0;
        w_resp_data = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (w_any_req) begin
                    w_latch = 1'b1;
                    if (w_in_range) begin
                        w_next = S_BUSY;
                    end else begin
                        w_next    = S_RESP;
                        w_set_oor = 1'b1;
                    end
                end
            end
            S_BUSY: begin
                if (bus.i_mem_ack) begin
                    w_fire      = 1'b1;
                    w_resp_data = r_cmd_wren ? 32'h0 : bus.i_mem_rdata;
                    w_next      = S_RESP;
                end else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    w_fire    = 1'b1;
                    w_set_tmo = 1'b1;
                    w_next    = S_RESP;
                end else begin
                    w_cnt_inc = 1'b1;
                end
            end
            S_RESP: begin
                if (r_hold) w_fire = 1'b1;
                else        w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_en_wren = w_latch ? w_sel_wren : r_cmd_wren;
    assign w_en      = (w_next == S_BUSY);

    // Command latch, timeout counter and round-robin history
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cmd_wren  <= 1'b0;
            r_cmd_addr  <= 32'h0;
            r_cmd_wdata <= 32'h0;
            r_cmd_bmask <= 4'h0;
            r_win_b     <= 1'b0;
            r_last_b    <= 1'b1;
            r_cnt       <= '0;
            r_hold      <= 1'b0;
        end else begin
            if (w_latch) begin
                r_cmd_wren  <= w_sel_wren;
                r_cmd_addr  <= w_sel_addr;
                r_cmd_wdata <= w_sel_wdata;
                r_cmd_bmask <= w_sel_bmask;
                r_win_b     <= w_sel_b;
                r_cnt       <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_set_oor)   r_hold <= 1'b1;
            else if (w_fire) r_hold <= 1'b0;
            if (w_fire) r_last_b <= r_win_b;
        end
    end

    // Registered outputs: memory enables, acks, response data, busy, errors
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_mem_wren <= 1'b0;
            r_mem_rden <= 1'b0;
            r_a_ack    <= 1'b0;
            r_b_ack    <= 1'b0;
            r_a_rdata  <= 32'h0;
            r_b_rdata  <= 32'h0;
            r_busy     <= 1'b0;
            r_err      <= 2'b00;
        end else begin
            r_mem_wren <= w_en & w_en_wren;
            r_mem_rden <= w_en & ~w_en_wren;
            r_a_ack    <= w_fire & ~r_win_b;
            r_b_ack    <= w_fire & r_win_b;
            if (w_fire & ~r_win_b) r_a_rdata <= w_resp_data;
            if (w_fire & r_win_b)  r_b_rdata <= w_resp_data;
            r_busy     <= (w_next != S_IDLE);
            r_err[0]   <= w_set_tmo | (r_err[0] & ~i_err_clr);
            r_err[1]   <= w_set_oor | (r_err[1] & ~i_err_clr);
        end
    end

    assign bus.o_mem_addr  = r_cmd_addr;
    assign bus.o_mem_wdata = r_cmd_wdata;
    assign bus.o_mem_bmask = r_cmd_bmask;
    assign bus.o_mem_wren  = r_mem_wren;
    assign bus.o_mem_rden  = r_mem_rden;
    assign bus.o_a_ack     = r_a_ack;
    assign bus.o_a_rdata   = r_a_rdata;
    assign bus.o_b_ack     = r_b_ack;
    assign bus.o_b_rdata   = r_b_rdata;
    assign o_busy          = r_busy;
    assign o_err           = r_err;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios followed by randomized
// transactions checked against a transaction-level model.
module tb_sram_arbiter;
    localparam logic [31:0] MIN = 32'h2000;
    localparam logic [31:0] MAX = 32'h3FFF;
    localparam int          TMO = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       err_clr;
    logic [1:0] err;
    logic       busy;

    sram_arbiter_if bus();

    sram_arbiter #(.SRAM_MIN(MIN), .SRAM_MAX(MAX), .TIMEOUT_CYC(TMO)) dut (
        .i_clk    (clk),
        .i_rst    (rst_n),
        .i_err_clr(err_clr),
        .o_err    (err),
        .o_busy   (busy),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          miscompares = 0;

    // Reference model state
    logic        m_last_b;
    logic [31:0] m_a_rdata;
    logic [31:0] m_b_rdata;
    logic [1:0]  m_err;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_last_b  = 1'b1;
        m_a_rdata = 32'h0;
        m_b_rdata = 32'h0;
        m_err     = 2'b00;
    endtask

    task automatic set_a(input logic req, input logic wr, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] bm);
        bus.i_a_req = req; bus.i_a_wren = wr; bus.i_a_addr = ad;
        bus.i_a_wdata = wd; bus.i_a_bmask = bm;
    endtask

    task automatic set_b(input logic req, input logic wr, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [3:0] bm);
        bus.i_b_req = req; bus.i_b_wren = wr; bus.i_b_addr = ad;
        bus.i_b_wdata = wd; bus.i_b_bmask = bm;
    endtask

    function automatic logic [31:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 15);
        case (sel)
            0:       return MIN;
            1:       return MAX;
            2:       return MIN - 32'h1;
            3:       return MAX + 32'h1;
            4:       return $urandom % MIN;
            5:       return MAX + 32'h1 + ($urandom % 32'h1000_0000);
            default: return MIN + ($urandom % (MAX - MIN + 32'h1));
        endcase
    endfunction

    // One complete transaction starting in an IDLE cycle with requests applied.
    // lat = BUSY cycle in which the controller acks (0 = never, forcing timeout).
    task automatic txn(input int lat, input logic [31:0] rd, input bit drop, output logic got_b);
        logic        win_b, wr, inr;
        logic [31:0] ad, wd, exp_rd;
        logic [3:0]  bm;
        int          n;
        win_b = bus.i_b_req && (!bus.i_a_req || !m_last_b);
        wr    = win_b ? bus.i_b_wren  : bus.i_a_wren;
        ad    = win_b ? bus.i_b_addr  : bus.i_a_addr;
        wd    = win_b ? bus.i_b_wdata : bus.i_a_wdata;
        bm    = win_b ? bus.i_b_bmask : bus.i_a_bmask;
        inr   = (ad >= MIN) && (ad <= MAX);
        m_err = (err_clr ? 2'b00 : m_err) | (inr ? 2'b00 : 2'b10);
        tick();
        err_clr = 1'b0;
        if (inr) begin
            n = (lat == 0) ? TMO : lat;
            for (int c = 1; c <= n; c++) begin
                chk("busy_rden",  bus.o_mem_rden, !wr);
                chk("busy_wren",  bus.o_mem_wren, wr);
                chk("busy_addr",  bus.o_mem_addr, ad);
                chk("busy_wdata", bus.o_mem_wdata, wd);
                chk("busy_bmask", bus.o_mem_bmask, bm);
                chk("busy_flag",  busy, 1'b1);
                chk("busy_acks",  {bus.o_a_ack, bus.o_b_ack}, 2'b00);
                chk("busy_err",   err, m_err);
                bus.i_mem_ack   = (c == lat);
                bus.i_mem_rdata = (c == lat) ? rd : $urandom;
                tick();
                bus.i_mem_ack = 1'b0;
            end
            exp_rd = (lat == 0 || wr) ? 32'h0 : rd;
            if (lat == 0) m_err[0] = 1'b1;
        end else begin
            chk("oor_en",   {bus.o_mem_wren, bus.o_mem_rden}, 2'b00);
            chk("oor_busy", busy, 1'b1);
            chk("oor_acks", {bus.o_a_ack, bus.o_b_ack}, 2'b00);
            chk("oor_err",  err, m_err);
            tick();
            exp_rd = 32'h0;
        end
        if (win_b) m_b_rdata = exp_rd;
        else       m_a_rdata = exp_rd;
        m_last_b = win_b;
        chk("resp_a_ack",   bus.o_a_ack, !win_b);
        chk("resp_b_ack",   bus.o_b_ack, win_b);
        chk("resp_a_rdata", bus.o_a_rdata, m_a_rdata);
        chk("resp_b_rdata", bus.o_b_rdata, m_b_rdata);
        chk("resp_err",     err, m_err);
        chk("resp_en",      {bus.o_mem_wren, bus.o_mem_rden}, 2'b00);
        chk("resp_busy",    busy, 1'b1);
        got_b = bus.o_b_ack;
        if (drop) begin
            if (win_b) bus.i_b_req = 1'b0;
            else       bus.i_a_req = 1'b0;
        end
        tick();
        chk("idle_acks", {bus.o_a_ack, bus.o_b_ack}, 2'b00);
        chk("idle_busy", busy, 1'b0);
        chk("idle_en",   {bus.o_mem_wren, bus.o_mem_rden}, 2'b00);
    endtask

    initial begin
        logic got_b;
        logic exp_b;
        int   lat;

        // Reset state
        rst_n = 1'b0;
        err_clr = 1'b0;
        set_a(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_b(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        bus.i_mem_ack = 1'b0;
        bus.i_mem_rdata = 32'h0;
        model_reset();
        tick(); tick();
        chk("rst_busy",  busy, 1'b0);
        chk("rst_err",   err, 2'b00);
        chk("rst_acks",  {bus.o_a_ack, bus.o_b_ack}, 2'b00);
        chk("rst_en",    {bus.o_mem_wren, bus.o_mem_rden}, 2'b00);
        chk("rst_rda",   bus.o_a_rdata, 32'h0);
        chk("rst_rdb",   bus.o_b_rdata, 32'h0);
        chk("rst_maddr", bus.o_mem_addr, 32'h0);
        #2 rst_n = 1'b1;
        tick();

        // A read, controller acks in third BUSY cycle
        set_a(1'b1, 1'b0, 32'h2004, 32'h0, 4'hF);
        txn(3, 32'hDEADBEEF, 1'b1, got_b);
        chk("a_read_winner", got_b, 1'b0);
        chk("a_read_rdata",  bus.o_a_rdata, 32'hDEADBEEF);

        // B write at top of range
        set_b(1'b1, 1'b1, 32'h3FFC, 32'h12345678, 4'b0011);
        txn(2, 32'hCAFEF00D, 1'b1, got_b);
        chk("b_write_winner", got_b, 1'b1);
        chk("b_write_rdata",  bus.o_b_rdata, 32'h0);
        chk("b_write_a_keep", bus.o_a_rdata, 32'hDEADBEEF);

        // Out-of-range read, then clear
        set_a(1'b1, 1'b0, 32'h7000, 32'h0, 4'hF);
        txn(1, 32'h11111111, 1'b1, got_b);
        chk("oor_err_flag", err, 2'b10);
        chk("oor_rdata",    bus.o_a_rdata, 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err = 2'b00;
        chk("err_clear", err, 2'b00);

        // Controller never acks
        set_a(1'b1, 1'b0, 32'h2040, 32'h0, 4'hF);
        txn(0, 32'h0, 1'b1, got_b);
        chk("tmo_err",   err, 2'b01);
        chk("tmo_rdata", bus.o_a_rdata, 32'h0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        m_err = 2'b00;

        // Reset mid-BUSY
        set_a(1'b1, 1'b0, 32'h2100, 32'h0, 4'hF);
        tick(); tick();
        chk("mid_rden", bus.o_mem_rden, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en",   {bus.o_mem_wren, bus.o_mem_rden}, 2'b00);
        chk("async_busy", busy, 1'b0);
        chk("async_ack",  {bus.o_a_ack, bus.o_b_ack}, 2'b00);
        chk("async_rdb",  bus.o_b_rdata, 32'h0);
        bus.i_a_req = 1'b0;
        model_reset();
        tick();
        chk("rst_hold_ack", bus.o_a_ack, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_busy", busy, 1'b0);
        chk("post_rst_ack",  bus.o_a_ack, 1'b0);

        // Both held from reset: A, B, A, B
        set_a(1'b1, 1'b0, 32'h2010, 32'h0, 4'hF);
        set_b(1'b1, 1'b0, 32'h2020, 32'h0, 4'hF);
        exp_b = 1'b0;
        for (int g = 0; g < 4; g++) begin
            txn(2, $urandom, 1'b0, got_b);
            chk("rr_grant", got_b, exp_b);
            exp_b = ~exp_b;
        end

        // Randomized transactions
        for (int r = 0; r < 150; r++) begin
            if (!bus.i_a_req && $urandom_range(0, 9) < 6)
                set_a(1'b1, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
            if (!bus.i_b_req && $urandom_range(0, 9) < 6)
                set_b(1'b1, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
            if (!bus.i_a_req && !bus.i_b_req) begin
                if ($urandom_range(0, 1) == 0)
                    set_a(1'b1, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
                else
                    set_b(1'b1, 1'($urandom), rand_addr(), $urandom, 4'($urandom));
            end
            err_clr = ($urandom_range(0, 3) == 0);
            lat = ($urandom_range(0, 24) == 0) ? 0 : int'($urandom_range(1, 5));
            txn(lat, $urandom, $urandom_range(0, 4) != 0, got_b);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter SRAM_MIN, default 32'h2000: lowest byte address forwarded to SRAM.
REQ-002 Parameter SRAM_MAX, default 32'h3FFF: highest byte address forwarded to SRAM.
REQ-003 Parameter TIMEOUT_CYC, default 64: maximum BUSY cycles waiting for i_mem_ack.
REQ-004 i_clk  in  1  clock; all logic on the rising edge.
REQ-005 i_rst  in  1  reset, asynchronous, active-low.
REQ-006 i_a_req  in  1  requester A (load/store) request; held high until o_a_ack.
REQ-007 i_a_wren  in  1  requester A: 1 = write, 0 = read.
REQ-008 i_a_addr  in  32  requester A byte address.
REQ-009 i_a_wdata  in  32  requester A write data.
REQ-010 i_a_bmask  in  4  requester A byte-lane enables.
REQ-011 o_a_ack  out  1  requester A one-cycle completion pulse.
REQ-012 o_a_rdata  out  32  requester A read data; valid with o_a_ack, held until the next A completion.
REQ-013 i_b_req, i_b_wren, i_b_addr, i_b_wdata, i_b_bmask, o_b_ack, o_b_rdata: same directions, widths and meanings as port A, for requester B (fetch/DMA).
REQ-014 o_mem_addr  out  32, o_mem_wdata  out  32, o_mem_bmask  out  4: latched command to the SRAM controller.
REQ-015 o_mem_wren  out  1, o_mem_rden  out  1: SRAM controller write/read enables.
REQ-016 i_mem_rdata  in  32, i_mem_ack  in  1: SRAM controller read data and completion.
REQ-017 i_err_clr  in  1  synchronous clear of o_err.
REQ-018 o_err  out  2  sticky error flags: [0] timeout, [1] address out of range.
REQ-019 o_busy  out  1  high in any state other than IDLE.

Function
REQ-020 FSM states: IDLE, BUSY, RESP.
REQ-021 IDLE: with any req high, select a winner, latch its wren/addr/wdata/bmask into command registers, clear the timeout counter, go to BUSY (addr in range) or RESP (addr out of range).
REQ-022 Arbitration is round-robin: single requester wins; if both are high, the port not served last wins; last-served register resets to B, so A wins the first tie.
REQ-023 BUSY: o_mem_wren = latched wren and o_mem_rden = ~latched wren, held high every BUSY cycle; o_mem_addr/wdata/bmask stay constant.
REQ-024 BUSY with i_mem_ack = 1: capture i_mem_rdata for reads (32'h0 for writes), go to RESP.
REQ-025 BUSY without ack: increment counter; on reaching TIMEOUT_CYC, set o_err[0], response data = 32'h0, go to RESP.
REQ-026 Out-of-range address (< SRAM_MIN or > SRAM_MAX): no memory enable asserted, set o_err[1], response data = 32'h0.
REQ-027 RESP: pulse winner's o_x_ack for exactly one cycle, drive its o_x_rdata, update last-served, return to IDLE; the other port's ack and rdata are unaffected.
REQ-028 Latency: req sampled in IDLE at cycle 0 -> enables high from cycle 1 -> ack at cycle k -> o_x_ack at cycle k+1; out-of-range -> o_x_ack at cycle 2.
REQ-029 A req dropping during BUSY or RESP does not abort; the transaction completes and ack still pulses.
REQ-030 Requests are not sampled in BUSY or RESP; at least one IDLE cycle separates transactions.
REQ-031 o_mem_wren and o_mem_rden are never high simultaneously; both are low outside BUSY.
REQ-032 i_err_clr clears o_err; an error set in the same cycle takes priority (flag stays set).

Reset
REQ-033 i_rst low: immediately force IDLE and clear o_mem_wren, o_mem_rden, o_a_ack, o_b_ack, o_busy, o_err, both rdata outputs, command registers, and timeout counter; set last-served to B.
REQ-034 Reset mid-BUSY abandons the transaction with no ack; after release, arbitration restarts from REQ-022.

Verification
REQ-035 A read 32'h2004, controller acks after 3 cycles with 32'hDEADBEEF -> o_mem_rden high cycles 1-3, o_a_ack at cycle 4, o_a_rdata = 32'hDEADBEEF.
REQ-036 A and B both request from reset -> A served first, then B; with both held continuously, grants alternate A, B, A, B.
REQ-037 B write 32'h3FFC data 32'h12345678 bmask 4'b0011 -> o_mem_wren high, o_mem_wdata = 32'h12345678, o_mem_bmask = 4'b0011, o_b_rdata = 0.
REQ-038 A read 32'h7000 -> no enable asserted, o_a_ack at cycle 2, rdata 0, o_err = 2'b10; i_err_clr -> o_err = 2'b00.
REQ-039 i_mem_ack never asserted -> o_a_ack after 64 BUSY cycles, o_err[0] = 1, rdata 0.
REQ-040 i_rst low during BUSY -> enables drop asynchronously, no ack pulse, o_busy = 0.
